// File: rtl/uart_prog_loader.sv
// Boot-time program loader: assembles little-endian UART bytes into 32-bit words, writes them
// to instruction memory over a req/gnt port, and releases the core reset on the end-of-program word.
module uart_prog_loader #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [31:0]        END_WORD  = 32'h0000_0FFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              rx_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
    typedef enum logic [1:0] {StIdle, StAssemble, StWrite, StDone} state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] tmr_q, tmr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_valid, frame_err;
    logic [15:0] cpb, half;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [7:0]        skid_data_q, skid_data_d;
    logic              err_q, err_d;
    logic              take;
    logic [7:0]        byte_in;

    assign cpb  = (clks_per_bit_i < 16'd4) ? 16'd4 : clks_per_bit_i;
    assign half = {1'b0, cpb[15:1]};

    // rx_s3_q is the previous synchronized sample, used only for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RIdle;
            tmr_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RIdle: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RStart;
                    tmr_d      = '0;
                end
            end
            RStart: begin
                if (tmr_q == half - 16'd1) begin
                    tmr_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s2_q ? RIdle : RData;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            RData: begin
                if (tmr_q == cpb - 16'd1) begin
                    tmr_d   = '0;
                    shreg_d = {rx_s2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RStop;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            RStop: begin
                if (tmr_q == cpb - 16'd1) begin
                    tmr_d      = '0;
                    rx_state_d = RIdle;
                    byte_valid = rx_s2_q;
                    frame_err  = !rx_s2_q;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: rx_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            wdata_q      <= '0;
            addr_q       <= BASE_ADDR;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        err_d        = err_q;
        take         = 1'b0;
        byte_in      = skid_valid_q ? skid_data_q : shreg_q;
        case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d      = StAssemble;
                    byte_cnt_d   = '0;
                    addr_d       = BASE_ADDR;
                    skid_valid_d = 1'b0;
                end
            end
            StAssemble: begin
                // The buffered byte goes first; a byte landing in the same cycle refills the buffer.
                if (skid_valid_q) begin
                    take         = 1'b1;
                    skid_valid_d = byte_valid;
                    if (byte_valid) begin
                        skid_data_d = shreg_q;
                    end
                end else begin
                    take = byte_valid;
                end
                if (take) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_d == END_WORD) begin
                            state_d = StDone;
                        end else begin
                            state_d = StWrite;
                            wdata_d = word_d;
                        end
                    end
                end
            end
            StWrite: begin
                if (byte_valid) begin
                    if (skid_valid_q) begin
                        err_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = shreg_q;
                    end
                end
                if (mem_gnt_i) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = StAssemble;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
        if (frame_err && (state_q == StAssemble || state_q == StWrite)) begin
            err_d = 1'b1;
        end
    end

    assign mem_req_o   = (state_q == StWrite);
    assign mem_we_o    = mem_req_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign core_rst_no = (state_q == StDone);
    assign done_o      = (state_q == StDone);
    assign busy_o      = (state_q == StAssemble) || (state_q == StWrite);
    assign err_o       = err_q;

endmodule
